// File: rtl/pong_pkg.sv
// pong_pkg: shared state codes and default sizing for the pong game controller
package pong_pkg;
  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;
  localparam int P_BALLS      = 3;
  localparam int P_TICK_DIV   = 833333;
  localparam int P_TIMER_LOAD = 120;
endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: player inputs, ball events and score/display outputs of the game sequencer
interface pong_game_ctrl_if import pong_pkg::*; #(parameter int BALLS = P_BALLS);
  localparam int BW = $clog2(BALLS + 1);
  logic [1:0]    btn;
  logic          hit;
  logic          miss;
  logic          d_inc;
  logic          d_clr;
  logic          gra_still;
  logic [BW-1:0] ball_left;
  logic [1:0]    state_o;
  logic          timer_up;
  modport master(output btn, hit, miss, input d_inc, d_clr, gra_still, ball_left, state_o, timer_up);
  modport slave(input btn, hit, miss, output d_inc, d_clr, gra_still, ball_left, state_o, timer_up);
endinterface

// File: rtl/pong_timer.sv
// pong_timer: free-running tick prescaler plus a loadable, saturating down-counter
module pong_timer import pong_pkg::*; #(
  parameter int TICK_DIV   = P_TICK_DIV,
  parameter int TIMER_LOAD = P_TIMER_LOAD
) (
  input  logic clk,
  input  logic reset,
  input  logic timer_start,
  output logic timer_up
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(TIMER_LOAD + 1);
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick     = presc == PW'(TICK_DIV - 1);
  assign timer_up = cnt == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      cnt   <= '0;
    end else if (timer_start) begin
      presc <= '0;
      cnt   <= CW'(TIMER_LOAD);
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && !timer_up) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: new-game/play/new-ball/over sequencer driving the score counter and ball count
module pong_game_ctrl import pong_pkg::*; #(
  parameter int BALLS      = P_BALLS,
  parameter int TICK_DIV   = P_TICK_DIV,
  parameter int TIMER_LOAD = P_TIMER_LOAD
) (
  input logic             clk,
  input logic             reset,
  pong_game_ctrl_if.slave bus
);
  localparam int BW = $clog2(BALLS + 1);
  state_t        state;
  logic [BW-1:0] bl;
  logic          timer_start;
  logic          timer_up;
  logic          press;
  assign press       = bus.btn != 2'b00;
  assign timer_start = state == PLAY && bus.miss && !bus.hit;
  pong_timer #(.TICK_DIV(TICK_DIV), .TIMER_LOAD(TIMER_LOAD)) u_timer (
    .clk(clk),
    .reset(reset),
    .timer_start(timer_start),
    .timer_up(timer_up)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NEWGAME;
      bl    <= BW'(BALLS);
    end else begin
      unique case (state)
        NEWGAME: begin
          bl <= press ? BW'(BALLS - 1) : BW'(BALLS);
          if (press) state <= PLAY;
        end
        PLAY: if (timer_start) begin
          if (bl == '0) state <= OVER;
          else begin
            state <= NEWBALL;
            bl    <= bl - 1'b1;
          end
        end
        NEWBALL: if (timer_up && press) state <= PLAY;
        OVER: if (timer_up) begin
          state <= NEWGAME;
          bl    <= BW'(BALLS);
        end
      endcase
    end
  end
  assign bus.d_inc     = state == PLAY && bus.hit;
  assign bus.d_clr     = state == NEWGAME;
  assign bus.gra_still = state != PLAY;
  assign bus.ball_left = bl;
  assign bus.state_o   = state;
  assign bus.timer_up  = timer_up;
endmodule
